// File: rtl/phase_ctrl.sv
// ---------------------------------------------------------------------------
// phase_ctrl
// Run-control sequencer for the cpu15 datapath. Steps a single-clock datapath
// through one-hot phase enables FT -> DC -> EX -> WB. The host/debug side can
// start, stop and single-step it. It halts on a HALT instruction, a PC
// breakpoint, or a stop/step request, and it counts retired instructions.
//
// Ports
//   CLK         system clock, all state changes on posedge
//   RESET       synchronous active-high reset, overrides every other input
//   START       pulse: continuous run (IDLE/HALT only)
//   STOP        pulse: halt after the current instruction
//   STEP        pulse: run exactly one instruction (IDLE/HALT only)
//   HALT_INSN   executing opcode is HALT (looked at in EX only)
//   BP_EN       breakpoint enable
//   BP_ADDR     breakpoint address
//   P_COUNT     next-instruction address from exec
//   EN_FT/DC/EX/WB  one-hot phase enables
//   BUSY        instruction in flight (FT..WB)
//   HALTED      sequencer parked in HALT
//   HALT_CAUSE  0 none, 1 HALT_INSN, 2 breakpoint, 3 STOP/STEP
//   INSN_CNT    retired instruction count, wraps modulo 2^ICNT_W
// ---------------------------------------------------------------------------
module phase_ctrl #(
    parameter int unsigned PC_W   = 8,
    parameter int unsigned ICNT_W = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic              STOP,
    input  logic              STEP,
    input  logic              HALT_INSN,
    input  logic              BP_EN,
    input  logic [PC_W-1:0]   BP_ADDR,
    input  logic [PC_W-1:0]   P_COUNT,
    output logic              EN_FT,
    output logic              EN_DC,
    output logic              EN_EX,
    output logic              EN_WB,
    output logic              BUSY,
    output logic              HALTED,
    output logic [1:0]        HALT_CAUSE,
    output logic [ICNT_W-1:0] INSN_CNT
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FT   = 3'd1,
        S_DC   = 3'd2,
        S_EX   = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_e;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_INSN = 2'd1;
    localparam logic [1:0] CAUSE_BP   = 2'd2;
    localparam logic [1:0] CAUSE_STOP = 2'd3;

    state_e            state_q, state_d;
    logic              step_mode_q, step_mode_d;
    logic              stop_pend_q, stop_pend_d;
    logic              halt_pend_q, halt_pend_d;
    logic [1:0]        cause_q, cause_d;
    logic [ICNT_W-1:0] cnt_q, cnt_d;

    // Output flops are loaded from the decoded next state, so they track the
    // state register exactly while coming straight from flops.
    logic              en_ft_q, en_ft_d;
    logic              en_dc_q, en_dc_d;
    logic              en_ex_q, en_ex_d;
    logic              en_wb_q, en_wb_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;

    logic              bp_hit_c;
    logic              stop_now_c;

    // Breakpoint looks at the PC of the instruction about to be fetched.
    assign bp_hit_c   = BP_EN && (P_COUNT == BP_ADDR);
    // A STOP landing in the WB cycle still counts for this instruction.
    assign stop_now_c = stop_pend_q || STOP;

    // Next-state, flag and output decode.
    always_comb begin
        state_d     = state_q;
        step_mode_d = step_mode_q;
        stop_pend_d = stop_pend_q;
        halt_pend_d = halt_pend_q;
        cause_d     = cause_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (START) begin
                    state_d     = S_FT;
                    step_mode_d = 1'b0;
                    cause_d     = CAUSE_NONE;
                end else if (STEP) begin
                    state_d     = S_FT;
                    step_mode_d = 1'b1;
                    cause_d     = CAUSE_NONE;
                end
            end
            S_FT: begin
                state_d     = S_DC;
                stop_pend_d = stop_pend_q || STOP;
            end
            S_DC: begin
                state_d     = S_EX;
                stop_pend_d = stop_pend_q || STOP;
            end
            S_EX: begin
                state_d     = S_WB;
                stop_pend_d = stop_pend_q || STOP;
                halt_pend_d = halt_pend_q || HALT_INSN;
            end
            S_WB: begin
                cnt_d       = cnt_q + ICNT_W'(1);
                stop_pend_d = 1'b0;
                halt_pend_d = 1'b0;
                if (halt_pend_q) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_INSN;
                end else if (bp_hit_c) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_BP;
                end else if (stop_now_c || step_mode_q) begin
                    state_d = S_HALT;
                    cause_d = CAUSE_STOP;
                end else begin
                    state_d = S_FT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        en_ft_d  = (state_d == S_FT);
        en_dc_d  = (state_d == S_DC);
        en_ex_d  = (state_d == S_EX);
        en_wb_d  = (state_d == S_WB);
        busy_d   = (state_d == S_FT) || (state_d == S_DC) ||
                   (state_d == S_EX) || (state_d == S_WB);
        halted_d = (state_d == S_HALT);
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            step_mode_q <= 1'b0;
            stop_pend_q <= 1'b0;
            halt_pend_q <= 1'b0;
            cause_q     <= CAUSE_NONE;
            cnt_q       <= '0;
            en_ft_q     <= 1'b0;
            en_dc_q     <= 1'b0;
            en_ex_q     <= 1'b0;
            en_wb_q     <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_mode_q <= step_mode_d;
            stop_pend_q <= stop_pend_d;
            halt_pend_q <= halt_pend_d;
            cause_q     <= cause_d;
            cnt_q       <= cnt_d;
            en_ft_q     <= en_ft_d;
            en_dc_q     <= en_dc_d;
            en_ex_q     <= en_ex_d;
            en_wb_q     <= en_wb_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
        end
    end

    assign EN_FT      = en_ft_q;
    assign EN_DC      = en_dc_q;
    assign EN_EX      = en_ex_q;
    assign EN_WB      = en_wb_q;
    assign BUSY       = busy_q;
    assign HALTED     = halted_q;
    assign HALT_CAUSE = cause_q;
    assign INSN_CNT   = cnt_q;

    // Phase enables never overlap and BUSY mirrors them.
    a_onehot: assert property (@(posedge CLK) disable iff (RESET)
        $onehot0({en_ft_q, en_dc_q, en_ex_q, en_wb_q}));
    a_busy: assert property (@(posedge CLK) disable iff (RESET)
        busy_q == (en_ft_q | en_dc_q | en_ex_q | en_wb_q));
    a_excl: assert property (@(posedge CLK) disable iff (RESET)
        !(busy_q && halted_q));

endmodule

// File: tb/tb_phase_ctrl.sv
// Testbench for phase_ctrl: each scenario pushes the expected output vector
// for a cycle when it drives that cycle's inputs, then pops and compares it
// once the clock edge has produced the DUT response.
module tb_phase_ctrl;

    typedef struct packed {
        logic [3:0]  en;      // {WB, EX, DC, FT}
        logic        busy;
        logic        halted;
        logic [1:0]  cause;
        logic [15:0] cnt;
    } obs_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        step_i;
    logic        halt_insn;
    logic        bp_en;
    logic [7:0]  bp_addr;
    logic [7:0]  pc;

    logic        en_ft, en_dc, en_ex, en_wb, busy, halted;
    logic [1:0]  cause;
    logic [15:0] cnt;

    logic        w_en_ft, w_en_dc, w_en_ex, w_en_wb, w_busy, w_halted;
    logic [1:0]  w_cause;
    logic [5:0]  w_cnt;

    int total = 0;
    int bad   = 0;
    obs_t exp_q[$];

    phase_ctrl dut (
        .CLK(clk), .RESET(rst), .START(start), .STOP(stop), .STEP(step_i),
        .HALT_INSN(halt_insn), .BP_EN(bp_en), .BP_ADDR(bp_addr), .P_COUNT(pc),
        .EN_FT(en_ft), .EN_DC(en_dc), .EN_EX(en_ex), .EN_WB(en_wb),
        .BUSY(busy), .HALTED(halted), .HALT_CAUSE(cause), .INSN_CNT(cnt)
    );

    // Narrow counter instance so counter wrap is reachable in a short run.
    phase_ctrl #(.PC_W(8), .ICNT_W(6)) dut_w (
        .CLK(clk), .RESET(rst), .START(start), .STOP(stop), .STEP(step_i),
        .HALT_INSN(halt_insn), .BP_EN(bp_en), .BP_ADDR(bp_addr), .P_COUNT(pc),
        .EN_FT(w_en_ft), .EN_DC(w_en_dc), .EN_EX(w_en_ex), .EN_WB(w_en_wb),
        .BUSY(w_busy), .HALTED(w_halted), .HALT_CAUSE(w_cause), .INSN_CNT(w_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ph: 0 IDLE, 1 FT, 2 DC, 3 EX, 4 WB, 5 HALT
    function automatic obs_t mk(int ph, int c, int n);
        obs_t o;
        o.en     = (ph >= 1 && ph <= 4) ? 4'(1 << (ph - 1)) : 4'b0000;
        o.busy   = (ph >= 1 && ph <= 4);
        o.halted = (ph == 5);
        o.cause  = 2'(c);
        o.cnt    = 16'(n);
        return o;
    endfunction

    // Phase at cycle k of a continuous run whose first FT is at cycle k0.
    function automatic int phr(int k, int k0);
        return ((k - k0) % 4) + 1;
    endfunction

    function automatic obs_t cur();
        obs_t o;
        o.en     = {en_wb, en_ex, en_dc, en_ft};
        o.busy   = busy;
        o.halted = halted;
        o.cause  = cause;
        o.cnt    = cnt;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; step_i = 1'b0; halt_insn = 1'b0;
        bp_en = 1'b0; bp_addr = 8'h00; pc = 8'h00;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e;
        rst = 1'b1; start = 1'b1; step_i = 1'b1; stop = 1'b1; halt_insn = 1'b1;
        bp_en = 1'b0; bp_addr = 8'h00; pc = 8'h00;
        exp_q.push_back(mk(0, 0, 0));
        tick();
        e = exp_q.pop_front(); total++;
        if (cur() !== e) begin bad++; $display("FAIL reset_idle got=%h want=%h", cur(), e); end
        total++;
        if (w_cnt !== 6'd0) begin bad++; $display("FAIL reset_cnt_w got=%0d want=0", w_cnt); end
        rst = 1'b0; start = 1'b0; step_i = 1'b0; stop = 1'b0; halt_insn = 1'b0;
        exp_q.push_back(mk(0, 0, 0));
        tick();
        e = exp_q.pop_front(); total++;
        if (cur() !== e) begin bad++; $display("FAIL idle_hold got=%h want=%h", cur(), e); end
        for (int k = 1; k <= 6; k++) begin
            step_i = (k == 1);
            rst    = (k == 6);
            exp_q.push_back(k <= 4 ? mk(k, 0, 0) : (k == 5 ? mk(5, 3, 1) : mk(0, 0, 0)));
            tick();
            e = exp_q.pop_front(); total++;
            if (cur() !== e) begin bad++; $display("FAIL reset_from_halt k=%0d got=%h want=%h", k, cur(), e); end
        end
        rst = 1'b0; step_i = 1'b0;
    endtask

    task automatic test_run();
        obs_t e;
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            start = (k == 1);
            stop  = (k == 14);
            exp_q.push_back(k <= 16 ? mk(phr(k, 1), 0, (k - 1) / 4) : mk(5, 3, 4));
            tick();
            e = exp_q.pop_front(); total++;
            if (cur() !== e) begin bad++; $display("FAIL run k=%0d got=%h want=%h", k, cur(), e); end
        end
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_step();
        obs_t e;
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            step_i = (k == 1) || (k == 6);
            stop   = (k == 5);
            if (k < 5)       exp_q.push_back(mk(k, 0, 0));
            else if (k == 5) exp_q.push_back(mk(5, 3, 1));
            else if (k < 10) exp_q.push_back(mk(k - 5, 0, 1));
            else             exp_q.push_back(mk(5, 3, 2));
            tick();
            e = exp_q.pop_front(); total++;
            if (cur() !== e) begin bad++; $display("FAIL step k=%0d got=%h want=%h", k, cur(), e); end
        end
        step_i = 1'b0; stop = 1'b0;
    endtask

    task automatic test_halt_insn();
        obs_t e;
        int j;
        do_reset();
        for (int k = 1; k <= 18; k++) begin
            j = k - 1;
            start     = (k == 1) || (k == 14);
            halt_insn = (j >= 1 && j <= 8 && phr(j, 1) != 3) || (j >= 9 && j <= 13);
            if (k <= 12)      exp_q.push_back(mk(phr(k, 1), 0, (k - 1) / 4));
            else if (k == 13) exp_q.push_back(mk(5, 1, 3));
            else if (k <= 17) exp_q.push_back(mk(k - 13, 0, 3));
            else              exp_q.push_back(mk(1, 0, 4));
            tick();
            e = exp_q.pop_front(); total++;
            if (cur() !== e) begin bad++; $display("FAIL halt_insn k=%0d got=%h want=%h", k, cur(), e); end
        end
        start = 1'b0; halt_insn = 1'b0;
    endtask

    task automatic test_breakpoint();
        obs_t e;
        int j;
        do_reset();
        bp_addr = 8'h05;
        for (int k = 1; k <= 22; k++) begin
            j = k - 1;
            start = (k == 1) || (k == 10);
            stop  = (j == 18);
            bp_en = (j != 17);
            pc    = (j == 4) ? 8'h04 : (j == 13) ? 8'h06 : (j >= 18) ? 8'h00 : 8'h05;
            if (k <= 8)       exp_q.push_back(mk(phr(k, 1), 0, (k - 1) / 4));
            else if (k == 9)  exp_q.push_back(mk(5, 2, 2));
            else if (k <= 21) exp_q.push_back(mk(phr(k, 10), 0, 2 + (k - 10) / 4));
            else              exp_q.push_back(mk(5, 3, 5));
            tick();
            e = exp_q.pop_front(); total++;
            if (cur() !== e) begin bad++; $display("FAIL breakpoint k=%0d got=%h want=%h", k, cur(), e); end
        end
        start = 1'b0; stop = 1'b0; bp_en = 1'b0; pc = 8'h00;
    endtask

    task automatic test_stop();
        obs_t e;
        int j;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            j = k - 1;
            start     = (k == 1) || (k == 6) || (k == 11);
            stop      = (j == 2) || (j == 7) || (j == 14) || (j == 15);
            halt_insn = (j == 3);
            if (k <= 4)       exp_q.push_back(mk(k, 0, 0));
            else if (k == 5)  exp_q.push_back(mk(5, 1, 1));
            else if (k <= 9)  exp_q.push_back(mk(k - 5, 0, 1));
            else if (k == 10) exp_q.push_back(mk(5, 3, 2));
            else if (k <= 14) exp_q.push_back(mk(k - 10, 0, 2));
            else              exp_q.push_back(mk(5, 3, 3));
            tick();
            e = exp_q.pop_front(); total++;
            if (cur() !== e) begin bad++; $display("FAIL stop k=%0d got=%h want=%h", k, cur(), e); end
        end
        start = 1'b0; stop = 1'b0; halt_insn = 1'b0;
    endtask

    task automatic test_reset_mid();
        obs_t e;
        do_reset();
        for (int k = 1; k <= 13; k++) begin
            start = (k == 1);
            rst   = (k == 12);
            exp_q.push_back(k <= 11 ? mk(phr(k, 1), 0, (k - 1) / 4) : mk(0, 0, 0));
            tick();
            e = exp_q.pop_front(); total++;
            if (cur() !== e) begin bad++; $display("FAIL reset_mid k=%0d got=%h want=%h", k, cur(), e); end
        end
        start = 1'b0; rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        obs_t e;
        do_reset();
        for (int k = 1; k <= 13; k++) begin
            start  = (k == 1) || (k == 4);
            step_i = (k == 1) || (k == 3) || (k == 7);
            stop   = (k == 10);
            exp_q.push_back(k <= 12 ? mk(phr(k, 1), 0, (k - 1) / 4) : mk(5, 3, 3));
            tick();
            e = exp_q.pop_front(); total++;
            if (cur() !== e) begin bad++; $display("FAIL back_to_back k=%0d got=%h want=%h", k, cur(), e); end
        end
        start = 1'b0; step_i = 1'b0; stop = 1'b0;
    endtask

    task automatic test_wrap();
        obs_t e;
        do_reset();
        for (int k = 1; k <= 257; k++) begin
            start = (k == 1);
            exp_q.push_back(mk(phr(k, 1), 0, (k - 1) / 4));
            tick();
            e = exp_q.pop_front(); total++;
            if (cur() !== e) begin bad++; $display("FAIL wrap_run k=%0d got=%h want=%h", k, cur(), e); end
            if (k == 253) begin
                total++;
                if (w_cnt !== 6'd63) begin bad++; $display("FAIL wrap_pre got=%0d want=63", w_cnt); end
            end
            if (k == 257) begin
                total++;
                if (w_cnt !== 6'd0) begin bad++; $display("FAIL wrap_zero got=%0d want=0", w_cnt); end
            end
        end
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; step_i = 1'b0; halt_insn = 1'b0;
        bp_en = 1'b0; bp_addr = 8'h00; pc = 8'h00;
        test_reset();
        test_run();
        test_step();
        test_halt_insn();
        test_breakpoint();
        test_stop();
        test_reset_mid();
        test_back_to_back();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
